// File: rtl/ysyx_22041071_div_ctrl_pkg.sv
// Shared definitions for the divide controller: data width, op and state encodings,
// and small decode helpers used by both the controller and its special-case logic.
package ysyx_22041071_div_ctrl_pkg;

  localparam int DIV_XLEN = 64;

  typedef enum logic [2:0] {
    OP_DIV   = 3'd0,
    OP_DIVU  = 3'd1,
    OP_REM   = 3'd2,
    OP_REMU  = 3'd3,
    OP_DIVW  = 3'd4,
    OP_DIVUW = 3'd5,
    OP_REMW  = 3'd6,
    OP_REMUW = 3'd7
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BUSY  = 3'd1,
    ST_SPEC  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    logic res;
    case (div_op_e'(op))
      OP_DIV, OP_REM, OP_DIVW, OP_REMW: res = 1'b1;
      default:                          res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    logic res;
    case (div_op_e'(op))
      OP_REM, OP_REMU, OP_REMW, OP_REMUW: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_w(input logic [2:0] op);
    logic res;
    case (div_op_e'(op))
      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: res = 1'b1;
      default:                              res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [DIV_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(DIV_XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [DIV_XLEN-1:0] zext32(input logic [31:0] v);
    return {{(DIV_XLEN-32){1'b0}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22041071_div_spec.sv
// Combinational helper: detects divide-by-zero / signed overflow on the effective
// operands and formats a final result (quotient/remainder select, W sign-extension).
module ysyx_22041071_div_spec
  import ysyx_22041071_div_ctrl_pkg::*;
(
  input  logic [2:0]          op,
  input  logic [DIV_XLEN-1:0] src1,
  input  logic [DIV_XLEN-1:0] src2,
  output logic                is_spec,
  output logic [DIV_XLEN-1:0] spec_quot,
  output logic [DIV_XLEN-1:0] spec_rema,
  input  logic [2:0]          res_op,
  input  logic [DIV_XLEN-1:0] res_quot,
  input  logic [DIV_XLEN-1:0] res_rema,
  output logic [DIV_XLEN-1:0] res_data
);

  logic                is_w;
  logic                is_signed;
  logic [DIV_XLEN-1:0] eff_a;
  logic [DIV_XLEN-1:0] eff_b;
  logic [DIV_XLEN-1:0] int_min;
  logic                div_zero;
  logic                overflow;
  logic [DIV_XLEN-1:0] sel;

  always_comb begin
    is_w      = op_is_w(op);
    is_signed = op_is_signed(op);
    eff_a     = src1;
    eff_b     = src2;
    if (is_w) begin
      eff_a = is_signed ? sext32(src1[31:0]) : zext32(src1[31:0]);
      eff_b = is_signed ? sext32(src2[31:0]) : zext32(src2[31:0]);
    end
    // W operands are sign-extended first, so the 32-bit minimum shows up sign-extended
    int_min   = is_w ? sext32(32'h8000_0000) : {1'b1, {(DIV_XLEN-1){1'b0}}};
    div_zero  = (eff_b == '0);
    overflow  = is_signed && (eff_a == int_min) && (eff_b == '1);
    is_spec   = div_zero || overflow;
    spec_quot = div_zero ? '1 : eff_a;
    spec_rema = div_zero ? eff_a : '0;
  end

  always_comb begin
    sel      = op_is_rem(res_op) ? res_rema : res_quot;
    res_data = op_is_w(res_op) ? sext32(sel[31:0]) : sel;
  end

endmodule

// File: rtl/ysyx_22041071_div_ctrl.sv
// Sequencer between the EX stage and an external iterative divider: accepts one op,
// short-circuits special cases, waits for the divider and emits a one-cycle writeback.
//
// state | meaning
// IDLE  | ready for a new op (ex_ready=1)
// BUSY  | divider running on registered operands (div_valid=1)
// SPEC  | special-case result already known, one cycle to DONE
// DONE  | wb_valid pulse with the formatted result
// DRAIN | op cancelled; wait for the divider to come back to idle
module ysyx_22041071_div_ctrl
  import ysyx_22041071_div_ctrl_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [2:0]      ex_op,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic [4:0]      ex_rd,
  output logic            ex_ready,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            div_valid,
  output logic            div_signed,
  output logic            divw,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] divisor,
  output logic            div_flush,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rema
);

  div_state_e      state_q;
  div_state_e      state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rema_q;

  logic            accept;
  logic            cap_div;
  logic            spec_hit;
  logic [XLEN-1:0] spec_quot;
  logic [XLEN-1:0] spec_rema;
  logic [XLEN-1:0] res_data;

  ysyx_22041071_div_spec u_spec (
    .op        (ex_op),
    .src1      (ex_src1),
    .src2      (ex_src2),
    .is_spec   (spec_hit),
    .spec_quot (spec_quot),
    .spec_rema (spec_rema),
    .res_op    (op_q),
    .res_quot  (quot_q),
    .res_rema  (rema_q),
    .res_data  (res_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      rd_q    <= '0;
      quot_q  <= '0;
      rema_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= ex_op;
        src1_q <= ex_src1;
        src2_q <= ex_src2;
        rd_q   <= ex_rd;
        // special-case results are final here; normal ops overwrite them on completion
        quot_q <= spec_quot;
        rema_q <= spec_rema;
      end else if (cap_div) begin
        quot_q <= div_quot;
        rema_q <= div_rema;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cap_div = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && !flush) begin
          accept  = 1'b1;
          state_d = spec_hit ? ST_SPEC : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (div_out_valid) begin
          cap_div = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_SPEC:  state_d = flush ? ST_IDLE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_DRAIN: begin
        // results arriving here belong to the cancelled op and are dropped
        if (div_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced to their idle values combinationally while reset is held.
  always_comb begin
    ex_ready   = reset || (state_q == ST_IDLE);
    wb_valid   = !reset && (state_q == ST_DONE) && !flush;
    wb_data    = (!reset && state_q == ST_DONE) ? res_data : '0;
    wb_rd      = (!reset && state_q == ST_DONE) ? rd_q : '0;
    div_valid  = !reset && (state_q == ST_BUSY);
    div_signed = !reset && op_is_signed(op_q);
    divw       = !reset && op_is_w(op_q);
    dividend   = reset ? '0 : src1_q;
    divisor    = reset ? '0 : src2_q;
    div_flush  = flush;
  end

endmodule

// File: tb/tb_ysyx_22041071_div_ctrl.sv
// Bench for the divide controller with a behavioural divider stub and a reference model.
module tb_ysyx_22041071_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [63:0] ex_src1;
  logic [63:0] ex_src2;
  logic [4:0]  ex_rd;
  logic        ex_ready;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        div_valid;
  logic        div_signed;
  logic        divw;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_flush;
  logic        div_ready;
  logic        div_out_valid;
  logic [63:0] div_quot;
  logic [63:0] div_rema;

  int n_tests = 0;
  int n_fail  = 0;
  int div_lat = 4;

  ysyx_22041071_div_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_op         (ex_op),
    .ex_src1       (ex_src1),
    .ex_src2       (ex_src2),
    .ex_rd         (ex_rd),
    .ex_ready      (ex_ready),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .div_valid     (div_valid),
    .div_signed    (div_signed),
    .divw          (divw),
    .dividend      (dividend),
    .divisor       (divisor),
    .div_flush     (div_flush),
    .div_ready     (div_ready),
    .div_out_valid (div_out_valid),
    .div_quot      (div_quot),
    .div_rema      (div_rema)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] eff_operand(input logic sgn, input logic w, input logic [63:0] x);
    logic [63:0] v;
    v = x;
    if (w) v = sgn ? {{32{x[31]}}, x[31:0]} : {32'h0, x[31:0]};
    return v;
  endfunction

  function automatic void div_arith(input logic sgn, input logic w, input logic [63:0] a_raw,
                                    input logic [63:0] b_raw, output logic [63:0] q,
                                    output logic [63:0] r);
    logic [63:0] a;
    logic [63:0] b;
    longint      sa;
    longint      sb;
    a  = eff_operand(sgn, w, a_raw);
    b  = eff_operand(sgn, w, b_raw);
    sa = a;
    sb = b;
    if (b == 64'h0) begin
      q = '1;
      r = a;
    end else if (sgn && b == '1 && a == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = a;
      r = 64'h0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Reference: op numbering 0..7 = DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
  function automatic void ref_model(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                                    output logic [63:0] res, output logic special);
    logic        sgn;
    logic        w;
    logic        rem;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] sel;
    w       = (op >= 3'd4);
    rem     = (op inside {3'd2, 3'd3, 3'd6, 3'd7});
    sgn     = (op inside {3'd0, 3'd2, 3'd4, 3'd6});
    a       = eff_operand(sgn, w, s1);
    b       = eff_operand(sgn, w, s2);
    special = (b == 64'h0) ||
              (sgn && b == '1 && a == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    div_arith(sgn, w, s1, s2, q, r);
    sel = rem ? r : q;
    res = w ? {{32{sel[31]}}, sel[31:0]} : sel;
  endfunction

  // Divider stub: fixed latency, a flush makes it linger two cycles with a stray result pulse.
  logic        dv_busy  = 1'b0;
  int          dv_cnt   = 0;
  int          dv_drain = 0;
  logic [63:0] dq;
  logic [63:0] dr;

  always @(posedge clk) begin
    if (reset) begin
      dv_busy  <= 1'b0;
      dv_cnt   <= 0;
      dv_drain <= 0;
    end else if (dv_busy && div_flush) begin
      dv_busy  <= 1'b0;
      dv_drain <= 2;
    end else if (dv_drain > 0) begin
      dv_drain <= dv_drain - 1;
    end else if (dv_busy) begin
      if (dv_cnt == 0) dv_busy <= 1'b0;
      else             dv_cnt  <= dv_cnt - 1;
    end else if (div_valid && !div_flush) begin
      dv_busy <= 1'b1;
      dv_cnt  <= div_lat - 1;
    end
  end

  always_comb begin
    dq = '0;
    dr = '0;
    div_arith(div_signed, divw, dividend, divisor, dq, dr);
    div_ready     = !dv_busy && (dv_drain == 0);
    div_out_valid = (dv_busy && dv_cnt == 0) || (dv_drain == 1);
    div_quot      = (dv_drain == 1) ? 64'hBAD0_BAD0_BAD0_BAD0 : dq;
    div_rema      = (dv_drain == 1) ? 64'h0BAD_0BAD_0BAD_0BAD : dr;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                       input logic [4:0] rd);
    int k;
    k = 0;
    while (!ex_ready && k < 60) begin
      step();
      k++;
    end
    chk("issue_ready", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_src1  = s1;
    ex_src2  = s2;
    ex_rd    = rd;
    step();
    ex_valid = 1'b0;
    ex_op    = 3'($urandom);
    ex_src1  = {$urandom, $urandom};
    ex_src2  = {$urandom, $urandom};
    ex_rd    = 5'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] s1,
                        input logic [63:0] s2, input logic [4:0] rd, input int lat,
                        output logic [63:0] got);
    logic [63:0] exp;
    logic        sp;
    logic        seen;
    logic        rdy_leak;
    logic        dv_leak;
    logic        hold;
    int          k;
    ref_model(op, s1, s2, exp, sp);
    div_lat = lat;
    issue(op, s1, s2, rd);
    k        = 1;
    seen     = 1'b0;
    rdy_leak = 1'b0;
    dv_leak  = 1'b0;
    hold     = 1'($urandom_range(1));
    while (k < lat + 30) begin
      if (wb_valid) begin
        seen = 1'b1;
        break;
      end
      if (ex_ready)  rdy_leak = 1'b1;
      if (div_valid) dv_leak  = 1'b1;
      ex_valid = hold;
      step();
      k++;
    end
    ex_valid = 1'b0;
    got      = wb_data;
    chk($sformatf("%s_wb_seen", tag), 64'(seen), 64'd1);
    chk($sformatf("%s_latency", tag), 64'(k), sp ? 64'd2 : 64'(lat + 2));
    chk($sformatf("%s_data", tag), wb_data, exp);
    chk($sformatf("%s_rd", tag), 64'(wb_rd), 64'(rd));
    chk($sformatf("%s_ready_low", tag), 64'(rdy_leak), 64'd0);
    if (sp) chk($sformatf("%s_no_div_valid", tag), 64'(dv_leak), 64'd0);
    step();
    chk($sformatf("%s_pulse", tag), 64'(wb_valid), 64'd0);
    chk($sformatf("%s_idle", tag), 64'(ex_ready), 64'd1);
  endtask

  task automatic watch_no_wb(input string tag, input int cycles);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (wb_valid) bad = 1'b1;
      step();
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(7))
      0:       v = 64'h0;
      1:       v = 64'h1;
      2:       v = '1;
      3:       v = 64'h8000_0000_0000_0000;
      4:       v = {$urandom, 32'h8000_0000};
      5:       v = {$urandom, 32'hFFFF_FFFF};
      6:       v = ($urandom_range(1) == 1) ? 64'($urandom_range(40)) : -64'($urandom_range(40));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] got;
    int          k;
    logic        bad;
    reset    = 1'b1;
    flush    = 1'b0;
    ex_valid = 1'b0;
    ex_op    = '0;
    ex_src1  = '0;
    ex_src2  = '0;
    ex_rd    = '0;
    step();
    step();
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_div_valid", 64'(div_valid), 64'd0);
    chk("rst_dividend", dividend, 64'd0);
    chk("rst_divisor", divisor, 64'd0);
    reset = 1'b0;
    step();

    run_op("div_20_m3", 3'd0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 6, got);
    chk("div_20_m3_lit", got, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("remu_7_0", 3'd3, 64'd7, 64'd0, 5'd2, 5, got);
    chk("remu_7_0_lit", got, 64'd7);
    run_op("divw_ovf", 3'd4, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd3, 5, got);
    chk("divw_ovf_lit", got, 64'hFFFF_FFFF_8000_0000);
    run_op("divuw_sext", 3'd5, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'd4, 3, got);
    chk("divuw_sext_lit", got, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("div_ovf64", 3'd0, 64'h8000_0000_0000_0000, '1, 5'd5, 4, got);
    run_op("rem_zero", 3'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 5'd6, 4, got);

    // flush 10 cycles into BUSY, then the divider must drain before the next op
    div_lat = 20;
    issue(3'd1, 64'd1000, 64'd3, 5'd7);
    repeat (9) step();
    flush = 1'b1;
    #1;
    chk("flush_div_flush", 64'(div_flush), 64'd1);
    step();
    flush = 1'b0;
    #1;
    chk("drain_ready_low", 64'(ex_ready), 64'd0);
    chk("drain_div_valid", 64'(div_valid), 64'd0);
    k   = 0;
    bad = 1'b0;
    while (!ex_ready && k < 40) begin
      if (wb_valid || div_valid) bad = 1'b1;
      step();
      k++;
    end
    chk("drain_no_wb", 64'(bad), 64'd0);
    chk("drain_back_idle", 64'(ex_ready), 64'd1);
    run_op("divu_9_2", 3'd1, 64'd9, 64'd2, 5'd8, 3, got);
    chk("divu_9_2_lit", got, 64'd4);

    // flush in SPEC
    issue(3'd3, 64'd7, 64'd0, 5'd9);
    flush = 1'b1;
    #1;
    chk("spec_flush_wb", 64'(wb_valid), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("spec_flush_idle", 64'(ex_ready), 64'd1);
    watch_no_wb("spec_flush_no_wb", 4);

    // flush in DONE
    issue(3'd3, 64'd7, 64'd0, 5'd10);
    step();
    flush = 1'b1;
    #1;
    chk("done_flush_wb", 64'(wb_valid), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("done_flush_idle", 64'(ex_ready), 64'd1);
    watch_no_wb("done_flush_no_wb", 4);

    // flush in IDLE blocks the accept
    ex_valid = 1'b1;
    ex_op    = 3'd3;
    ex_src1  = 64'd7;
    ex_src2  = 64'd0;
    ex_rd    = 5'd11;
    flush    = 1'b1;
    step();
    ex_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("idle_flush_ready", 64'(ex_ready), 64'd1);
    watch_no_wb("idle_flush_no_wb", 4);

    // reset in BUSY
    div_lat = 20;
    issue(3'd0, 64'd100, 64'd7, 5'd12);
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("busy_rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("busy_rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("busy_rst_wb_data", wb_data, 64'd0);
    chk("busy_rst_div_valid", 64'(div_valid), 64'd0);
    chk("busy_rst_dividend", dividend, 64'd0);
    chk("busy_rst_divisor", divisor, 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_idle", 64'(ex_ready), 64'd1);
    chk("post_rst_div_valid", 64'(div_valid), 64'd0);
    watch_no_wb("post_rst_no_wb", 30);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(7)), pick(), pick(),
             5'($urandom), $urandom_range(1, 8), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_div_ctrl.md
YSYX_22041071_DIV_CTRL -- requirements
Module: ysyx_22041071_div_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; cancels the pending divide
- ex_valid  in  1  EX stage presents a divide op
- ex_op  in  3  {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW} = 0..7
- ex_src1  in  64  dividend
- ex_src2  in  64  divisor
- ex_rd  in  5  destination register
- ex_ready  out  1  op accepted when ex_valid & ex_ready
- wb_valid  out  1  one-cycle result pulse
- wb_data  out  64  result
- wb_rd  out  5  destination register of the result
- div_valid  out  1  to divider
- div_signed  out  1  to divider
- divw  out  1  to divider
- dividend  out  64  to divider
- divisor  out  64  to divider
- div_flush  out  1  to divider
- div_ready  in  1  divider idle
- div_out_valid  in  1  divider result valid
- div_quot  in  64  divider quotient
- div_rema  in  64  divider remainder

REQ-002 SHALL have parameter XLEN, default 64, meaning the data width; only 64 is supported.

Function
REQ-003 SHALL implement states IDLE, BUSY, SPEC, DONE, DRAIN.
REQ-004 In IDLE, ex_ready SHALL be 1; in every other state, ex_ready SHALL be 0.
REQ-005 On accept (IDLE, ex_valid, no flush), the block SHALL register op, src1, src2 and rd.
REQ-006 On accept, if the op is a special case, the next state SHALL be SPEC; otherwise it SHALL be BUSY.
REQ-007 Special cases are evaluated on the effective operands:
- W ops: low 32 bits.
- Divide by zero: divisor == 0.
- Signed overflow: dividend is the most negative value and divisor is -1.
REQ-008 Divide by zero SHALL give quotient all ones and remainder = effective dividend.
REQ-009 Signed overflow SHALL give quotient = effective dividend and remainder = 0.
REQ-010 In BUSY, div_valid SHALL be 1 and dividend/divisor/div_signed/divw SHALL come from the registered operands.
REQ-011 Those divider inputs SHALL stay stable for the whole of BUSY, because the divider samples its signs combinationally until its result.
REQ-012 BUSY→DONE SHALL occur on the cycle div_out_valid=1; div_quot/div_rema SHALL be captured in that cycle.
REQ-013 BUSY SHALL NOT be left before div_out_valid, other than by flush.
REQ-014 div_valid SHALL be 0 in all states except BUSY, so the divider cannot restart after it returns to idle.
REQ-015 SPEC→DONE SHALL take one cycle.
REQ-016 DONE→IDLE SHALL take one cycle, with wb_valid=1 in DONE only.
REQ-017 Result selection: DIV/DIVU/DIVW/DIVUW SHALL select the quotient; REM variants SHALL select the remainder.
REQ-018 W results SHALL be the low 32 bits sign-extended from bit 31 to 64, for signed and unsigned W ops alike.
REQ-019 Latency from accept to wb_valid SHALL be 2 cycles for special cases, and divider latency + 2 cycles otherwise.
REQ-020 div_flush SHALL equal flush.
REQ-021 Flush in BUSY SHALL move the block to DRAIN, and no wb_valid SHALL be produced for the cancelled op.
REQ-022 Flush in SPEC or DONE SHALL move the block to IDLE and suppress wb_valid in that cycle.
REQ-023 Flush in IDLE SHALL block accept in that cycle.
REQ-024 DRAIN SHALL hold div_valid=0, discard any div_out_valid, and return to IDLE on the first cycle div_ready=1 after the divider has left its busy states.
REQ-025 A new ex_valid SHALL NOT be accepted in the same cycle wb_valid=1.

Reset
REQ-026 reset SHALL force IDLE and clear all registered operands and result registers to 0.
REQ-027 While reset is asserted, outputs SHALL be: ex_ready=1, wb_valid=0, wb_data=0, wb_rd=0, div_valid=0, dividend=0, divisor=0.
REQ-028 Reset SHALL take priority over flush and over handshakes.
REQ-029 Reset mid-operation SHALL abandon the op with no wb_valid, and the divider SHALL be reset by the same reset.

Structure
REQ-030 The op encodings, state encodings and XLEN SHALL be placed in the shared define header.
REQ-031 The special-case detect and W sign-extension logic SHALL be one combinational sub-module, ysyx_22041071_div_spec.
REQ-032 The divider SHALL be instantiated outside this block.

Verification
REQ-033 DIV 20 / -3 SHALL produce wb_data = -6 after the divider completes, with ex_ready=0 throughout.
REQ-034 REMU 7 / 0 SHALL produce wb_data = 7 two cycles after accept, and div_valid SHALL never assert.
REQ-035 DIVW 0x80000000 / 0xFFFFFFFF SHALL produce wb_data = 0xFFFFFFFF80000000, with no divider use.
REQ-036 DIVUW 0xFFFFFFFE / 1 SHALL produce wb_data = 0xFFFFFFFFFFFFFFFE (sign-extended).
REQ-037 Flush 10 cycles into BUSY SHALL give: DRAIN, no wb_valid, then a next DIVU 9/2 returning 4 correctly.
REQ-038 Reset asserted in BUSY SHALL give IDLE next cycle with all outputs at reset values, and no stale wb_valid afterward.
